// File: rtl/mdio_generator.sv
// Clause-22 MDIO station-management generator: divides CLK into MDC, serialises a
// 32-bit management frame onto MDIO and captures 16 read-data bits for read frames.
module mdio_generator #(
    parameter int unsigned HALF_PERIOD   = 2,
    parameter int unsigned PREAMBLE_BITS = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic        MDC,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic [15:0] RD_DATA,
    output logic        MDIO_DONE
);

    localparam int unsigned HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int unsigned CW = $clog2(PREAMBLE_BITS + 33);

    localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] PRE_LAST   = CW'(PREAMBLE_BITS);
    localparam logic [CW-1:0] HDR_BITS   = CW'(16);
    localparam logic [CW-1:0] FRAME_BITS = CW'(32);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StPre,
        StXmit,
        StRd,
        StDone
    } state_e;

    state_e        state;
    logic [HW-1:0] half_cnt;
    logic [CW-1:0] bit_cnt;
    logic [31:0]   shadow;
    logic          is_read;
    logic [15:0]   rd_shift;
    logic          half_end;
    logic          fall_tick;
    logic          rise_tick;

    always_comb begin
        half_end  = (half_cnt == HALF_LAST);
        fall_tick = half_end & MDC;
        rise_tick = half_end & ~MDC;
    end

    // MDC runs continuously, independent of frame activity.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            half_cnt <= '0;
            MDC      <= 1'b0;
        end else if (half_end) begin
            half_cnt <= '0;
            MDC      <= ~MDC;
        end else begin
            half_cnt <= half_cnt + HW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= StIdle;
            bit_cnt   <= '0;
            shadow    <= '0;
            is_read   <= 1'b0;
            rd_shift  <= '0;
            MDIO_OUT  <= 1'b0;
            MDIO_OE   <= 1'b0;
            RD_DATA   <= '0;
            MDIO_DONE <= 1'b0;
        end else begin
            MDIO_DONE <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (MDIO_START) begin
                        shadow  <= T_DATA;
                        is_read <= (T_DATA[29:28] == 2'b10);
                        bit_cnt <= '0;
                        state   <= StWait;
                    end
                end
                StWait: begin
                    if (fall_tick) begin
                        MDIO_OE <= 1'b1;
                        bit_cnt <= CW'(1);
                        if (PREAMBLE_BITS > 0) begin
                            MDIO_OUT <= 1'b1;
                            state    <= StPre;
                        end else begin
                            MDIO_OUT <= shadow[31];
                            shadow   <= {shadow[30:0], 1'b0};
                            state    <= StXmit;
                        end
                    end
                end
                StPre: begin
                    if (fall_tick) begin
                        if (bit_cnt == PRE_LAST) begin
                            MDIO_OUT <= shadow[31];
                            shadow   <= {shadow[30:0], 1'b0};
                            bit_cnt  <= CW'(1);
                            state    <= StXmit;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                StXmit: begin
                    if (fall_tick) begin
                        // Reads release the line after the 16-bit header.
                        if (bit_cnt == (is_read ? HDR_BITS : FRAME_BITS)) begin
                            MDIO_OE  <= 1'b0;
                            MDIO_OUT <= 1'b0;
                            bit_cnt  <= '0;
                            if (is_read) begin
                                state <= StRd;
                            end else begin
                                MDIO_DONE <= 1'b1;
                                state     <= StDone;
                            end
                        end else begin
                            MDIO_OUT <= shadow[31];
                            shadow   <= {shadow[30:0], 1'b0};
                            bit_cnt  <= bit_cnt + CW'(1);
                        end
                    end
                end
                StRd: begin
                    if (rise_tick && (bit_cnt != HDR_BITS)) begin
                        rd_shift <= {rd_shift[14:0], MDIO_IN};
                        bit_cnt  <= bit_cnt + CW'(1);
                    end else if (fall_tick && (bit_cnt == HDR_BITS)) begin
                        RD_DATA   <= rd_shift;
                        MDIO_DONE <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_generator.sv
// Bench for mdio_generator: frame-level reference model checks every MDC rise of
// table-driven and random frames on a plain and a 32-bit-preamble instance.
module tb_mdio_generator;

    localparam int HP   = 2;
    localparam int PRE1 = 32;

    typedef struct {
        bit          sel;
        logic [31:0] tdata;
        logic [15:0] phy;
        logic [15:0] exp_rd;
        bit          busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [31:0] td0 = '0;
    logic [31:0] td1 = '0;
    logic        mi0 = 1'b1;
    logic        mi1 = 1'b1;
    logic        mdc0, out0, oe0, done0;
    logic        mdc1, out1, oe1, done1;
    logic [15:0] rd0, rd1;

    int checks   = 0;
    int failures = 0;
    logic [15:0] rd_model [2];
    vec_t vecs [$];

    always #5 clk = ~clk;

    mdio_generator #(.HALF_PERIOD(HP), .PREAMBLE_BITS(0)) dut (
        .CLK(clk), .RESET(rst), .MDIO_START(start0), .T_DATA(td0), .MDIO_IN(mi0),
        .MDC(mdc0), .MDIO_OUT(out0), .MDIO_OE(oe0), .RD_DATA(rd0), .MDIO_DONE(done0)
    );

    mdio_generator #(.HALF_PERIOD(HP), .PREAMBLE_BITS(PRE1)) dut_pre (
        .CLK(clk), .RESET(rst), .MDIO_START(start1), .T_DATA(td1), .MDIO_IN(mi1),
        .MDC(mdc1), .MDIO_OUT(out1), .MDIO_OE(oe1), .RD_DATA(rd1), .MDIO_DONE(done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_le(input string name, input int act, input int limit);
        checks++;
        if (act > limit) begin
            failures++;
            $display("FAIL %s: actual=%0d required<=%0d", name, act, limit);
        end
    endtask

    task automatic sample(input bit sel, output logic mdc, output logic oe, output logic out,
                          output logic done, output logic [15:0] rd);
        if (sel) begin
            mdc = mdc1; oe = oe1; out = out1; done = done1; rd = rd1;
        end else begin
            mdc = mdc0; oe = oe0; out = out0; done = done0; rd = rd0;
        end
    endtask

    task automatic drive(input bit sel, input logic st, input logic [31:0] td, input logic mi);
        if (sel) begin
            start1 = st; td1 = td; mi1 = mi;
        end else begin
            start0 = st; td0 = td; mi0 = mi;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mdc"}, {31'd0, mdc0}, 32'd0);
        check({tag, "_oe"}, {31'd0, oe0}, 32'd0);
        check({tag, "_out"}, {31'd0, out0}, 32'd0);
        check({tag, "_done"}, {31'd0, done0}, 32'd0);
        check({tag, "_rd"}, {16'd0, rd0}, 32'd0);
        check({tag, "_pre_oe"}, {31'd0, oe1}, 32'd0);
        check({tag, "_pre_rd"}, {16'd0, rd1}, 32'd0);
    endtask

    // One complete frame; each MDC rise is compared with the bit the frame rules require.
    task automatic run_frame(input vec_t v);
        int pre = v.sel ? PRE1 : 0;
        bit is_rd = (v.tdata[29:28] == 2'b10);
        int total = pre + 32;
        int bound = (pre + 33) * 2 * HP + 2;
        int n = 0;
        int dones = 0;
        int done_c = -1;
        int last_rise = 0;
        bit started = 1'b0;
        logic prev_mdc, mdc, oe, out, done, mi, exp_oe, exp_out;
        logic [15:0] rd;
        int k;
        @(negedge clk);
        sample(v.sel, mdc, oe, out, done, rd);
        prev_mdc = mdc;
        drive(v.sel, 1'b1, v.tdata, 1'b1);
        for (int c = 1; c <= bound + 10; c++) begin
            @(negedge clk);
            sample(v.sel, mdc, oe, out, done, rd);
            if (mdc && !prev_mdc && (started || oe)) begin
                if (started) check("mdc_period", c - last_rise, 2 * HP);
                started = 1'b1;
                last_rise = c;
                if (n < total) begin
                    k = n - pre;
                    if (n < pre) begin
                        exp_oe = 1'b1; exp_out = 1'b1;
                    end else if (is_rd && k >= 16) begin
                        exp_oe = 1'b0; exp_out = 1'b0;
                    end else begin
                        exp_oe = 1'b1; exp_out = v.tdata[31-k];
                    end
                    check($sformatf("rise%0d_oe", n), {31'd0, oe}, {31'd0, exp_oe});
                    check($sformatf("rise%0d_out", n), {31'd0, out}, {31'd0, exp_out});
                end else begin
                    check("extra_rise_oe", {31'd0, oe}, 32'd0);
                end
                n++;
            end
            prev_mdc = mdc;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    done_c = c;
                    check_le("done_latency", c, bound);
                    check("rises_at_done", n, total);
                    check("rd_data", {16'd0, rd}, {16'd0, v.exp_rd});
                    check("oe_at_done", {31'd0, oe}, 32'd0);
                end
            end
            mi = 1'b1;
            if (n >= pre + 16 && n < pre + 32) mi = v.phy[15-(n-pre-16)];
            if (v.busy && c == 40) drive(v.sel, 1'b1, 32'h5000_0000, mi);
            else drive(v.sel, 1'b0, $urandom, mi);
            if (done_c > 0 && c >= done_c + 8) break;
        end
        drive(v.sel, 1'b0, '0, 1'b1);
        check("done_count", dones, 1);
    endtask

    task automatic abort_read();
        logic mdc, oe, out, done;
        logic [15:0] rd;
        int dones = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h6A5E_0000, 1'b1);
        for (int c = 0; c < 21 * 2 * HP; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, '0, c[0]);
            sample(1'b0, mdc, oe, out, done, rd);
            if (done) dones++;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b0;
        rd_model[0] = '0;
        rd_model[1] = '0;
        for (int c = 0; c < 40 * 2 * HP; c++) begin
            @(negedge clk);
            sample(1'b0, mdc, oe, out, done, rd);
            if (done) dones++;
        end
        check("abort_done_count", dones, 0);
        check("abort_rd_after", {16'd0, rd0}, 32'd0);
    endtask

    initial begin
        vec_t v;
        logic [31:0] r;
        logic [1:0] op;
        rd_model[0] = '0;
        rd_model[1] = '0;

        // Fixed frames: write with busy poke, read returning BEEF, preamble write.
        vecs.push_back('{1'b0, 32'h5A5E_1234, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{1'b0, 32'h6A5E_FFFF, 16'hBEEF, 16'hBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h5000_0001, 16'h0000, 16'h0000, 1'b0});
        rd_model[0] = 16'hBEEF;
        for (int i = 0; i < 8; i++) begin
            r = $urandom;
            op = 2'($urandom_range(0, 3));
            v.sel = (i % 3 == 2);
            v.tdata = {2'b01, op, r[27:0]};
            v.phy = 16'($urandom);
            v.busy = 1'b0;
            if (op == 2'b10) rd_model[v.sel] = v.phy;
            v.exp_rd = rd_model[v.sel];
            vecs.push_back(v);
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mdc_after_edge1", {31'd0, mdc0}, 32'd0);
        @(negedge clk);
        check("mdc_after_edge2", {31'd0, mdc0}, 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        foreach (vecs[i]) run_frame(vecs[i]);

        abort_read();
        v = '{1'b0, 32'h5123_4567, 16'h0000, 16'h0000, 1'b0};
        run_frame(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
